tx_resp_sched: RTL and testbench
================================

TX_RESP_SCHED -- requirements
Module: tx_resp_sched

Interface
REQ-001 SHALL have parameter width, default 8, byte width of register-file data and UART Tx data.
REQ-002 SHALL have parameter depth, default 4, response-FIFO entries in bytes; power of two, minimum 4.
REQ-003 SHALL have parameter TO_CYC, default 64, number of CLK cycles allowed for Busy to rise after a send.
REQ-004 SHALL have port CLK, input, 1 bit: single clock (REF domain); all logic is rising-edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Rd_data, input, width bits: register-file read byte.
REQ-007 SHALL have port Rd_valid, input, 1 bit: single-cycle strobe qualifying Rd_data.
REQ-008 SHALL have port ALU_out, input, 2*width bits: ALU result.
REQ-009 SHALL have port ALU_out_valid, input, 1 bit: single-cycle strobe qualifying ALU_out.
REQ-010 SHALL have port Busy, input, 1 bit: synchronized UART-Tx busy level.
REQ-011 SHALL have port Tx_Data, output, width bits: byte presented to the Tx data synchronizer.
REQ-012 SHALL have port Tx_Data_valid, output, 1 bit: single-cycle send strobe.
REQ-013 SHALL have port Ovf, output, 1 bit: sticky flag, set when a request is dropped.
REQ-014 SHALL have port Tmo, output, 1 bit: sticky flag, set on a Busy timeout.
REQ-015 SHALL have port Pending, output, 1 bit: high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-016 SHALL, on a sampled ALU_out_valid, push two bytes: ALU_out[width-1:0] first, then ALU_out[2*width-1:width].
REQ-017 SHALL, on a sampled Rd_valid, push one byte, Rd_data.
REQ-018 SHALL, when both strobes are sampled in the same cycle, write the ALU bytes ahead of the Rd byte, all three in that cycle.
REQ-019 SHALL base free space on the registered count before any same-cycle pop.
REQ-020 SHALL evaluate the ALU request first and the Rd request against the space remaining after it.
REQ-021 SHALL drop a request whole if it does not fit (never a partial push) and set Ovf.
REQ-022 SHALL use read and write pointers that wrap modulo depth, with a count ranging from 0 to depth inclusive.
REQ-023 SHALL allow a push and a pop in the same cycle, with count updated by the net change.
REQ-024 SHALL implement an FSM with states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-025 SHALL, in IDLE with count>0 and Busy=0: pop the head byte into Tx_Data, pulse Tx_Data_valid for exactly one cycle, and go to WAIT_BUSY.
REQ-026 SHALL, in WAIT_BUSY: go to WAIT_DONE when Busy=1; otherwise, after TO_CYC cycles, set Tmo and go to IDLE with no resend.
REQ-027 SHALL, in WAIT_DONE: go to IDLE when Busy=0.
REQ-028 SHALL hold Tx_Data stable from the pop until the next pop.
REQ-029 SHALL give a latency of 2 edges: a strobe sampled at edge N, with the FIFO empty, FSM in IDLE and Busy=0, gives Tx_Data_valid=1 in the cycle after edge N+1.
REQ-030 SHALL never assert Tx_Data_valid while Busy=1 or outside IDLE.
REQ-031 SHALL clear Ovf and Tmo only on Reset.

Reset
REQ-032 SHALL, on Reset=1 at a rising edge: set FSM to IDLE, pointers/count/timeout counter to 0, Tx_Data to 0, and Tx_Data_valid, Ovf, Tmo and Pending to 0.
REQ-033 SHALL discard any queued bytes and abandon any in-flight wait when reset occurs mid-operation.
REQ-034 SHALL ignore strobes in a cycle where Reset=1.

Structure
REQ-035 SHALL place the FSM state encodings and the default width/depth/TO_CYC constants in shared package sys_pkg.
REQ-036 SHALL implement the byte storage as sub-module resp_fifo (3-byte write port, 1-byte read port, count output).
REQ-037 SHALL keep the FSM and timeout counter in tx_resp_sched.

Verification
REQ-038 SHALL cover: Rd_valid with Rd_data=0xA5, Busy=0 -> Tx_Data=0xA5, one-cycle Tx_Data_valid 2 edges later; Busy pulse high then low -> IDLE, Pending=0.
REQ-039 SHALL cover: ALU_out=0x1234 valid, Busy emulated by UART model -> bytes sent 0x34 then 0x12, second only after Busy falls.
REQ-040 SHALL cover: ALU_out=0xBEEF and Rd_data=0x5A in the same cycle -> send order 0xEF, 0xBE, 0x5A; Ovf=0.
REQ-041 SHALL cover: depth=4 with Busy held 1 (nothing sent), pushes ALU 0x1111, ALU 0x2222, then Rd 0x33 -> FIFO holds 4 bytes, Rd dropped, Ovf=1; release Busy -> exactly 0x11, 0x11, 0x22, 0x22 sent.
REQ-042 SHALL cover: after a send, Busy stays 0 for 64 cycles -> Tmo=1, FSM IDLE, next queued byte sent, no resend of the first.
REQ-043 SHALL cover: Reset asserted in WAIT_DONE with 2 bytes queued -> next cycle all outputs 0 and count 0; after release, no stale bytes are transmitted.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared constants and FSM encoding for the UART Tx response scheduler.
package sys_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int TO_CYC_DEF = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/resp_fifo.sv
// Byte FIFO for response data: up to three bytes written per cycle, one byte read.
module resp_fifo
  import sys_pkg::*;
#(
  parameter int width = WIDTH_DEF,
  parameter int depth = DEPTH_DEF
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic [1:0]                   wr_num,
  input  logic [3*width-1:0]           wr_data,
  input  logic                         rd_en,
  output logic [width-1:0]             rd_data,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr_num);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_q + CW'(wr_num) - CW'(rd_en);
    end
  end

  // NOTE: storage is not reset; clearing the pointers and count already makes old bytes unreachable.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      for (int i = 0; i < 3; i++) begin
        if (i < int'(wr_num)) mem_q[wr_ptr_q + AW'(i)] <= wr_data[i*width +: width];
      end
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/tx_resp_sched.sv
// Queues register-read and ALU result bytes and hands them one at a time to the UART Tx path.
module tx_resp_sched
  import sys_pkg::*;
#(
  parameter int width  = WIDTH_DEF,
  parameter int depth  = DEPTH_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [width-1:0]     Rd_data,
  input  logic                 Rd_valid,
  input  logic [2*width-1:0]   ALU_out,
  input  logic                 ALU_out_valid,
  input  logic                 Busy,
  output logic [width-1:0]     Tx_Data,
  output logic                 Tx_Data_valid,
  output logic                 Ovf,
  output logic                 Tmo,
  output logic                 Pending
);

  localparam int CW = $clog2(depth+1);
  localparam int TW = $clog2(TO_CYC+1);

  tx_state_e        state_q;
  logic [TW-1:0]    tmo_cnt_q;
  logic [CW-1:0]    count;
  logic [CW-1:0]    free;
  logic [width-1:0] head;
  logic             alu_ok;
  logic             rd_ok;
  logic             drop;
  logic             pop;
  logic [1:0]       wr_num;
  logic [3*width-1:0] wr_data;

  // NOTE: combinational logic uses blocking assignments, each signal given a value on every path.
  always_comb begin
    free    = CW'(depth) - count;
    alu_ok  = ALU_out_valid && (free >= CW'(2));
    rd_ok   = Rd_valid && ((free - (alu_ok ? CW'(2) : CW'(0))) >= CW'(1));
    drop    = (ALU_out_valid && !alu_ok) || (Rd_valid && !rd_ok);
    wr_num  = {1'b0, rd_ok} + (alu_ok ? 2'd2 : 2'd0);
    // ALU low byte lands first, Rd byte last; without an ALU push the Rd byte goes in slot 0.
    wr_data = alu_ok ? {Rd_data, ALU_out} : {{(2*width){1'b0}}, Rd_data};
    pop     = (state_q == IDLE) && (count != '0) && !Busy;
  end

  resp_fifo #(
    .width (width),
    .depth (depth)
  ) u_fifo (
    .CLK     (CLK),
    .Reset   (Reset),
    .wr_num  (wr_num),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= IDLE;
      tmo_cnt_q     <= '0;
      Tx_Data       <= '0;
      Tx_Data_valid <= 1'b0;
      Ovf           <= 1'b0;
      Tmo           <= 1'b0;
    end else begin
      Tx_Data_valid <= 1'b0;
      if (drop) Ovf <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            Tx_Data       <= head;
            Tx_Data_valid <= 1'b1;
            tmo_cnt_q     <= '0;
            state_q       <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (Busy) begin
            tmo_cnt_q <= '0;
            state_q   <= WAIT_DONE;
          end else if (tmo_cnt_q == TW'(TO_CYC-1)) begin
            // The byte is abandoned, not resent; the next queued byte goes out instead.
            Tmo       <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!Busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Pending = (count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_tx_resp_sched.sv
// Self-checking bench for tx_resp_sched: vector table, UART busy model and a send scoreboard.
module tb_tx_resp_sched;

  localparam int TO_CYC = 64;
  localparam int B_MODEL = 0, B_HI = 1, B_LO = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rd_data = '0;
  logic        rd_v = 1'b0;
  logic [15:0] alu_out = '0;
  logic        alu_v = 1'b0;
  logic        busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        ovf, tmo, pending;

  int          n_vec = 0;
  int          n_err = 0;
  int          busy_mode = B_MODEL;
  int          busy_cnt = 0;
  int          sends_seen = 0;
  logic        busy_at_neg = 1'b0;
  logic [7:0]  sb[$];

  typedef struct {
    logic        alu_v;
    logic [15:0] alu;
    logic        rd_v;
    logic [7:0]  rd;
    int          n;
    logic [23:0] bytes;   // expected send order, first byte in bits 7:0
  } vec_t;

  vec_t vt[5];

  tx_resp_sched dut (
    .CLK           (clk),
    .Reset         (reset),
    .Rd_data       (rd_data),
    .Rd_valid      (rd_v),
    .ALU_out       (alu_out),
    .ALU_out_valid (alu_v),
    .Busy          (busy),
    .Tx_Data       (tx_data),
    .Tx_Data_valid (tx_valid),
    .Ovf           (ovf),
    .Tmo           (tmo),
    .Pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART model: raises Busy the cycle after a send and holds it for four cycles.
  initial forever begin
    @(posedge clk); #1;
    if (busy_mode == B_HI) begin
      busy = 1'b1; busy_cnt = 0;
    end else if (busy_mode == B_LO) begin
      busy = 1'b0; busy_cnt = 0;
    end else begin
      if (tx_valid) busy_cnt = 4;
      if (busy_cnt > 0) begin busy = 1'b1; busy_cnt--; end
      else busy = 1'b0;
    end
  end

  // Send monitor: every strobe must match the scoreboard head and come while Busy is low.
  initial forever begin
    @(negedge clk); busy_at_neg = busy;
    @(posedge clk); #1;
    if (tx_valid) begin
      sends_seen++;
      check("busy_low_at_send", {31'b0, busy_at_neg}, 0);
      if (sb.size() == 0) check("send_expected", {31'b0, tx_valid}, 0);
      else check("tx_byte", {24'b0, tx_data}, {24'b0, sb.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic av, input logic [15:0] a, input logic rv, input logic [7:0] r);
    @(negedge clk);
    alu_v = av; alu_out = a; rd_v = rv; rd_data = r;
    @(negedge clk);
    alu_v = 1'b0; rd_v = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while ((pending || busy) && n < max_cyc);
    check(name, {31'b0, pending}, 0);
  endtask

  task automatic wait_send(input int max_cyc, input string name);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (!tx_valid && n < max_cyc);
    check(name, {31'b0, tx_valid}, 1);
  endtask

  initial begin
    int s0, n;
    vt[0] = '{1'b0, 16'h0000, 1'b1, 8'hC3, 1, 24'h0000C3};
    vt[1] = '{1'b1, 16'h1234, 1'b0, 8'h00, 2, 24'h001234};
    vt[2] = '{1'b1, 16'hBEEF, 1'b1, 8'h5A, 3, 24'h5ABEEF};
    vt[3] = '{1'b0, 16'h0000, 1'b1, 8'h00, 1, 24'h000000};
    vt[4] = '{1'b1, 16'h00FF, 1'b1, 8'hFF, 3, 24'hFF00FF};

    // Reset, with a strobe present that must be ignored.
    rd_v = 1'b1; rd_data = 8'hEE;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; rd_v = 1'b0;
    @(posedge clk); #2;
    check("rst_tx_data", {24'b0, tx_data}, 0);
    check("rst_tx_valid", {31'b0, tx_valid}, 0);
    check("rst_ovf", {31'b0, ovf}, 0);
    check("rst_tmo", {31'b0, tmo}, 0);
    check("rst_pending", {31'b0, pending}, 0);

    // Two-edge latency and one-cycle strobe.
    sb.push_back(8'hA5);
    @(negedge clk); rd_v = 1'b1; rd_data = 8'hA5;
    @(posedge clk);
    @(negedge clk); rd_v = 1'b0;
    @(posedge clk); #2;
    check("lat_valid", {31'b0, tx_valid}, 1);
    check("lat_data", {24'b0, tx_data}, 8'hA5);
    @(posedge clk); #2;
    check("lat_pulse_width", {31'b0, tx_valid}, 0);
    wait_idle(50, "lat_idle");
    check("lat_sb_empty", sb.size(), 0);

    // Table vectors, each drained by the UART model before the next.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vt[i].n; k++) sb.push_back(vt[i].bytes[k*8 +: 8]);
      drive(vt[i].alu_v, vt[i].alu, vt[i].rd_v, vt[i].rd);
      wait_idle(200, $sformatf("vec%0d_idle", i));
      check($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
      check($sformatf("vec%0d_hold", i), {24'b0, tx_data}, {24'b0, vt[i].bytes[(vt[i].n-1)*8 +: 8]});
      check($sformatf("vec%0d_ovf", i), {31'b0, ovf}, 0);
    end

    // Overflow: Busy held high, FIFO fills with four bytes, Rd request dropped whole.
    busy_mode = B_HI;
    @(negedge clk);
    s0 = sends_seen;
    sb.push_back(8'h11); sb.push_back(8'h11);
    drive(1'b1, 16'h1111, 1'b0, 8'h00);
    sb.push_back(8'h22); sb.push_back(8'h22);
    drive(1'b1, 16'h2222, 1'b0, 8'h00);
    drive(1'b0, 16'h0000, 1'b1, 8'h33);
    @(posedge clk); #2;
    check("ovf_set", {31'b0, ovf}, 1);
    check("ovf_nothing_sent", sends_seen - s0, 0);
    check("ovf_pending", {31'b0, pending}, 1);
    @(negedge clk); busy_mode = B_MODEL;
    wait_idle(200, "ovf_idle");
    check("ovf_sends", sends_seen - s0, 4);
    check("ovf_sb_empty", sb.size(), 0);
    check("ovf_sticky", {31'b0, ovf}, 1);

    // Timeout: Busy never rises; each byte is abandoned after TO_CYC cycles, never resent.
    busy_mode = B_LO;
    s0 = sends_seen;
    sb.push_back(8'h61); sb.push_back(8'h62);
    @(negedge clk); alu_v = 1'b1; alu_out = 16'h6261;
    @(negedge clk); alu_v = 1'b0;
    wait_send(10, "tmo_first_send");
    n = 0;
    while (!tmo && n < 200) begin @(posedge clk); #2; n++; end
    check("tmo_cycles", n, TO_CYC);
    check("tmo_pending", {31'b0, pending}, 1);
    wait_idle(400, "tmo_idle");
    check("tmo_sticky", {31'b0, tmo}, 1);
    check("tmo_sends", sends_seen - s0, 2);
    check("tmo_sb_empty", sb.size(), 0);

    // Reset in WAIT_DONE with two bytes still queued.
    busy_mode = B_MODEL;
    sb.push_back(8'h70);
    @(negedge clk); alu_v = 1'b1; alu_out = 16'h7170; rd_v = 1'b1; rd_data = 8'h72;
    @(negedge clk); alu_v = 1'b0; rd_v = 1'b0;
    wait_send(10, "mid_rst_send");
    @(negedge clk);
    @(negedge clk); reset = 1'b1; busy_mode = B_LO;
    @(posedge clk); #2;
    check("mid_rst_tx_data", {24'b0, tx_data}, 0);
    check("mid_rst_tx_valid", {31'b0, tx_valid}, 0);
    check("mid_rst_ovf", {31'b0, ovf}, 0);
    check("mid_rst_tmo", {31'b0, tmo}, 0);
    check("mid_rst_pending", {31'b0, pending}, 0);
    @(negedge clk); reset = 1'b0; busy_mode = B_MODEL;
    s0 = sends_seen;
    repeat (30) @(posedge clk);
    #2;
    check("mid_rst_no_stale", sends_seen - s0, 0);
    check("mid_rst_pending_after", {31'b0, pending}, 0);
    check("mid_rst_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
